// File: rtl/dccm_port_arbiter.sv
// dccm_port_arbiter: LSU/DMA arbiter for the DCCM low-bank port with 1-cycle read response steering.
// Define DCCM_ARB_STARVE_EN to enable the DMA starvation counter and DMA_FORCE state.
module dccm_port_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 39,
  parameter int DMA_MAX_WAIT = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              lsu_req_valid,
  input  logic              lsu_req_write,
  input  logic [ADDR_W-1:0] lsu_req_addr,
  input  logic [DATA_W-1:0] lsu_req_wdata,
  output logic              lsu_req_ready,
  input  logic              dma_req_valid,
  input  logic              dma_req_write,
  input  logic [ADDR_W-1:0] dma_req_addr,
  input  logic [DATA_W-1:0] dma_req_wdata,
  output logic              dma_req_ready,
  output logic              dccm_wren,
  output logic              dccm_rden,
  output logic [ADDR_W-1:0] dccm_wr_addr_lo,
  output logic [ADDR_W-1:0] dccm_rd_addr_lo,
  output logic [DATA_W-1:0] dccm_wr_data_lo,
  input  logic [DATA_W-1:0] dccm_rd_data_lo,
  output logic              lsu_rsp_valid,
  output logic              dma_rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              dma_starved
);
  logic force_dma;
  logic dma_win;
  logic lsu_win;
  logic win_write;
  logic lsu_rsp_q, lsu_rsp_d;
  logic dma_rsp_q, dma_rsp_d;
`ifdef DCCM_ARB_STARVE_EN
  localparam int CW = $clog2(DMA_MAX_WAIT + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(DMA_MAX_WAIT);
  typedef enum logic {NORMAL, DMA_FORCE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= NORMAL;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end
  always_comb begin
    state_d    = (state_q == DMA_FORCE) ? (dma_win ? NORMAL : DMA_FORCE)
               : ((wait_cnt_q == MAX_CNT) && !dma_win) ? DMA_FORCE : NORMAL;
    wait_cnt_d = (dma_win || !dma_req_valid || force_dma) ? '0
               : (wait_cnt_q == MAX_CNT) ? wait_cnt_q : wait_cnt_q + 1'b1;
  end
  always_comb begin
    force_dma   = (state_q == DMA_FORCE);
    dma_starved = force_dma;
  end
`else
  logic unused_cfg;
  assign unused_cfg  = (DMA_MAX_WAIT != 0);
  assign force_dma   = 1'b0;
  assign dma_starved = 1'b0;
`endif
  // Idle cycles leave the LSU fields on the memory bus so DMA noise never toggles it.
  always_comb begin
    dma_win         = !reset && dma_req_valid && (force_dma || !lsu_req_valid);
    lsu_win         = !reset && lsu_req_valid && !dma_win;
    win_write       = dma_win ? dma_req_write : lsu_req_write;
    lsu_req_ready   = lsu_win;
    dma_req_ready   = dma_win;
    dccm_wren       = (lsu_win || dma_win) && win_write;
    dccm_rden       = (lsu_win || dma_win) && !win_write;
    dccm_wr_addr_lo = dma_win ? dma_req_addr : lsu_req_addr;
    dccm_rd_addr_lo = dma_win ? dma_req_addr : lsu_req_addr;
    dccm_wr_data_lo = dma_win ? dma_req_wdata : lsu_req_wdata;
    lsu_rsp_d       = lsu_win && !lsu_req_write;
    dma_rsp_d       = dma_win && !dma_req_write;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lsu_rsp_q <= 1'b0;
      dma_rsp_q <= 1'b0;
    end else begin
      lsu_rsp_q <= lsu_rsp_d;
      dma_rsp_q <= dma_rsp_d;
    end
  end
  assign lsu_rsp_valid = lsu_rsp_q;
  assign dma_rsp_valid = dma_rsp_q;
  assign rsp_data      = dccm_rd_data_lo;
endmodule

// File: tb/tb_dccm_port_arbiter.sv
// tb_dccm_port_arbiter: directed self-checking bench for dccm_port_arbiter with a small DCCM model.
module tb_dccm_port_arbiter;
  localparam int AW = 16;
  localparam int DW = 39;
  logic          clock = 1'b0;
  logic          reset;
  logic          lsu_req_valid, lsu_req_write, lsu_req_ready;
  logic [AW-1:0] lsu_req_addr;
  logic [DW-1:0] lsu_req_wdata;
  logic          dma_req_valid, dma_req_write, dma_req_ready;
  logic [AW-1:0] dma_req_addr;
  logic [DW-1:0] dma_req_wdata;
  logic          dccm_wren, dccm_rden;
  logic [AW-1:0] dccm_wr_addr_lo, dccm_rd_addr_lo;
  logic [DW-1:0] dccm_wr_data_lo, dccm_rd_data_lo;
  logic          lsu_rsp_valid, dma_rsp_valid, dma_starved;
  logic [DW-1:0] rsp_data;
  int pass_cnt = 0;
  int total    = 0;

  dccm_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DMA_MAX_WAIT(8)) dut (
    .clock(clock), .reset(reset),
    .lsu_req_valid(lsu_req_valid), .lsu_req_write(lsu_req_write), .lsu_req_addr(lsu_req_addr),
    .lsu_req_wdata(lsu_req_wdata), .lsu_req_ready(lsu_req_ready),
    .dma_req_valid(dma_req_valid), .dma_req_write(dma_req_write), .dma_req_addr(dma_req_addr),
    .dma_req_wdata(dma_req_wdata), .dma_req_ready(dma_req_ready),
    .dccm_wren(dccm_wren), .dccm_rden(dccm_rden),
    .dccm_wr_addr_lo(dccm_wr_addr_lo), .dccm_rd_addr_lo(dccm_rd_addr_lo),
    .dccm_wr_data_lo(dccm_wr_data_lo), .dccm_rd_data_lo(dccm_rd_data_lo),
    .lsu_rsp_valid(lsu_rsp_valid), .dma_rsp_valid(dma_rsp_valid),
    .rsp_data(rsp_data), .dma_starved(dma_starved)
  );

  always #5 clock = ~clock;

  function automatic logic [DW-1:0] fill(input logic [15:0] a);
    return {23'h55AA11, a};
  endfunction

  logic [DW-1:0] mem [0:1023];
  logic [DW-1:0] rd_q;
  always @(posedge clock) begin
    if (reset) for (int i = 0; i < 1024; i++) mem[i] <= fill(i[15:0]);
    else if (dccm_wren) mem[dccm_wr_addr_lo[9:0]] <= dccm_wr_data_lo;
    if (dccm_rden) rd_q <= mem[dccm_rd_addr_lo[9:0]];
  end
  assign dccm_rd_data_lo = rd_q;

  task automatic cyc();
    @(posedge clock);
    @(negedge clock);
    #1;
  endtask

  task automatic idle();
    lsu_req_valid = 0; lsu_req_write = 0; lsu_req_addr = 16'h0033; lsu_req_wdata = '0;
    dma_req_valid = 0; dma_req_write = 0; dma_req_addr = 16'h0077; dma_req_wdata = '0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1;
    lsu_req_valid = 1; lsu_req_addr = 16'h0040; dma_req_valid = 1;
    repeat (3) cyc();
    total++;
    if ({lsu_req_ready, dma_req_ready, dccm_rden, dccm_wren, lsu_rsp_valid, dma_rsp_valid, dma_starved} !== 7'b0) begin
      $display("FAIL reset_hold: outputs=%b expected=0000000", {lsu_req_ready, dma_req_ready, dccm_rden, dccm_wren, lsu_rsp_valid, dma_rsp_valid, dma_starved});
    end else pass_cnt++;
    reset = 0;
    #1;
    total++;
    if ({lsu_req_ready, dma_req_ready, dccm_rden} !== 3'b101) begin
      $display("FAIL reset_release_grant: rdy/rden=%b expected=101", {lsu_req_ready, dma_req_ready, dccm_rden});
    end else pass_cnt++;
    @(posedge clock);
    #2 reset = 1;
    @(negedge clock);
    #1;
    total++;
    if ({lsu_rsp_valid, dma_rsp_valid, dccm_rden, dccm_wren, lsu_req_ready, dma_req_ready, dma_starved} !== 7'b0) begin
      $display("FAIL reset_mid_read: outputs=%b expected=0000000", {lsu_rsp_valid, dma_rsp_valid, dccm_rden, dccm_wren, lsu_req_ready, dma_req_ready, dma_starved});
    end else pass_cnt++;
    idle();
    reset = 0;
    cyc();
    total++;
    if ({lsu_rsp_valid, dma_rsp_valid} !== 2'b00) begin
      $display("FAIL reset_drop_rsp: rsp_valid=%b expected=00", {lsu_rsp_valid, dma_rsp_valid});
    end else pass_cnt++;
  endtask

  task automatic test_priority();
    idle();
    lsu_req_valid = 1; lsu_req_addr = 16'h0040;
    dma_req_valid = 1; dma_req_addr = 16'h0080;
    #1;
    total++;
    if ({lsu_req_ready, dma_req_ready, dccm_rden, dccm_wren} !== 4'b1010) begin
      $display("FAIL prio_grant: rdy/rden/wren=%b expected=1010", {lsu_req_ready, dma_req_ready, dccm_rden, dccm_wren});
    end else pass_cnt++;
    total++;
    if (dccm_rd_addr_lo !== 16'h0040) begin
      $display("FAIL prio_addr: rd_addr=%h expected=0040", dccm_rd_addr_lo);
    end else pass_cnt++;
    cyc();
    idle();
    #1;
    total++;
    if ({lsu_rsp_valid, dma_rsp_valid} !== 2'b10) begin
      $display("FAIL prio_rsp_valid: rsp=%b expected=10", {lsu_rsp_valid, dma_rsp_valid});
    end else pass_cnt++;
    total++;
    if (rsp_data !== fill(16'h0040)) begin
      $display("FAIL prio_rsp_data: data=%h expected=%h", rsp_data, fill(16'h0040));
    end else pass_cnt++;
    total++;
    if ({dccm_rden, dccm_wren, dccm_rd_addr_lo, dccm_wr_addr_lo} !== {2'b00, 16'h0033, 16'h0033}) begin
      $display("FAIL idle_hold_lsu: en=%b rd=%h wr=%h expected en=00 rd=0033 wr=0033", {dccm_rden, dccm_wren}, dccm_rd_addr_lo, dccm_wr_addr_lo);
    end else pass_cnt++;
    cyc();
    dma_req_valid = 1; dma_req_write = 1; dma_req_addr = 16'h0080; dma_req_wdata = 39'h7F_0BADCAFE;
    #1;
    total++;
    if ({lsu_req_ready, dma_req_ready, dccm_rden, dccm_wren, dccm_wr_addr_lo, dccm_wr_data_lo} !== {4'b0101, 16'h0080, 39'h7F_0BADCAFE}) begin
      $display("FAIL dma_alone_write: rdy/en=%b addr=%h data=%h expected 0101 0080 7f0badcafe", {lsu_req_ready, dma_req_ready, dccm_rden, dccm_wren}, dccm_wr_addr_lo, dccm_wr_data_lo);
    end else pass_cnt++;
    cyc();
    idle();
    #1;
    total++;
    if ({lsu_rsp_valid, dma_rsp_valid} !== 2'b00) begin
      $display("FAIL write_no_rsp: rsp=%b expected=00", {lsu_rsp_valid, dma_rsp_valid});
    end else pass_cnt++;
    cyc();
  endtask

  task automatic test_back_to_back();
    idle();
    lsu_req_valid = 1; lsu_req_write = 1; lsu_req_addr = 16'h0010; lsu_req_wdata = 39'h12_3456789A;
    #1;
    total++;
    if ({dccm_wren, dccm_rden, dccm_wr_addr_lo, dccm_wr_data_lo} !== {2'b10, 16'h0010, 39'h12_3456789A}) begin
      $display("FAIL b2b_write: en=%b addr=%h data=%h expected 10 0010 123456789a", {dccm_wren, dccm_rden}, dccm_wr_addr_lo, dccm_wr_data_lo);
    end else pass_cnt++;
    cyc();
    lsu_req_write = 0;
    #1;
    total++;
    if ({dccm_wren, dccm_rden, dccm_rd_addr_lo} !== {2'b01, 16'h0010}) begin
      $display("FAIL b2b_read: en=%b addr=%h expected 01 0010", {dccm_wren, dccm_rden}, dccm_rd_addr_lo);
    end else pass_cnt++;
    cyc();
    idle();
    #1;
    total++;
    if ({lsu_rsp_valid, rsp_data} !== {1'b1, 39'h12_3456789A}) begin
      $display("FAIL b2b_rsp: valid=%b data=%h expected 1 123456789a", lsu_rsp_valid, rsp_data);
    end else pass_cnt++;
    cyc();
  endtask

  task automatic test_alternating();
    int rsp_seen = 0;
    logic [15:0] prev_addr = '0;
    logic prev_dma = 1'b0;
    for (int i = 0; i < 17; i++) begin
      idle();
      if (i < 16) begin
        if (i % 2 == 0) begin lsu_req_valid = 1; lsu_req_addr = 16'(16'h0200 + i); end
        else begin dma_req_valid = 1; dma_req_addr = 16'(16'h0300 + i); end
      end
      #1;
      if (i > 0) begin
        total++;
        if ({lsu_rsp_valid, dma_rsp_valid} !== {!prev_dma, prev_dma}) begin
          $display("FAIL alt_src[%0d]: rsp=%b expected=%b", i - 1, {lsu_rsp_valid, dma_rsp_valid}, {!prev_dma, prev_dma});
        end else pass_cnt++;
        total++;
        if (rsp_data !== fill(prev_addr)) begin
          $display("FAIL alt_data[%0d]: data=%h expected=%h", i - 1, rsp_data, fill(prev_addr));
        end else pass_cnt++;
      end
      rsp_seen += int'(lsu_rsp_valid) + int'(dma_rsp_valid);
      prev_dma  = (i % 2 == 1);
      prev_addr = prev_dma ? 16'(16'h0300 + i) : 16'(16'h0200 + i);
      cyc();
    end
    total++;
    if (rsp_seen !== 16) begin
      $display("FAIL alt_count: responses=%0d expected=16", rsp_seen);
    end else pass_cnt++;
  endtask

`ifdef DCCM_ARB_STARVE_EN
  task automatic test_starvation();
    for (int c = 0; c < 12; c++) begin
      idle();
      lsu_req_valid = 1; lsu_req_addr = 16'h0020;
      dma_req_valid = (c <= 9); dma_req_write = 1; dma_req_addr = 16'h0100; dma_req_wdata = 39'h01_00000100;
      #1;
      total++;
      if ({lsu_req_ready, dma_req_ready, dma_starved} !== {c != 9, c == 9, c == 9}) begin
        $display("FAIL starve_c%0d: lsu/dma/starved=%b expected=%b", c, {lsu_req_ready, dma_req_ready, dma_starved}, {c != 9, c == 9, c == 9});
      end else pass_cnt++;
      if (c == 9) begin
        total++;
        if ({dccm_wren, dccm_wr_addr_lo} !== {1'b1, 16'h0100}) begin
          $display("FAIL starve_write: wren=%b addr=%h expected 1 0100", dccm_wren, dccm_wr_addr_lo);
        end else pass_cnt++;
      end
      cyc();
    end
  endtask

  task automatic test_force_withdraw();
    for (int c = 0; c < 13; c++) begin
      idle();
      lsu_req_valid = 1; lsu_req_addr = 16'h0020;
      dma_req_valid = (c <= 8) || (c == 11); dma_req_addr = 16'h0080;
      #1;
      if (c >= 9) begin
        total++;
        if ({lsu_req_ready, dma_req_ready, dma_starved} !== {c != 11, c == 11, c <= 11}) begin
          $display("FAIL withdraw_c%0d: lsu/dma/starved=%b expected=%b", c, {lsu_req_ready, dma_req_ready, dma_starved}, {c != 11, c == 11, c <= 11});
        end else pass_cnt++;
      end
      cyc();
    end
  endtask
`else
  task automatic test_strict_priority();
    for (int c = 0; c < 50; c++) begin
      idle();
      lsu_req_valid = 1; lsu_req_addr = 16'h0020;
      dma_req_valid = 1; dma_req_addr = 16'h0100;
      #1;
      total++;
      if ({lsu_req_ready, dma_req_ready, dma_starved} !== 3'b100) begin
        $display("FAIL strict_c%0d: lsu/dma/starved=%b expected=100", c, {lsu_req_ready, dma_req_ready, dma_starved});
      end else pass_cnt++;
      cyc();
    end
  endtask
`endif

  initial begin
    test_reset();
    test_priority();
    test_back_to_back();
    test_alternating();
`ifdef DCCM_ARB_STARVE_EN
    test_starvation();
    test_force_withdraw();
`else
    test_strict_priority();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/dccm_port_arbiter.md
# dccm_port_arbiter

Two-requester arbiter and sequencer for the DCCM low-bank port of the memory wrapper. It shares the port between the load/store unit (LSU) and the DMA slave:
- The LSU has priority by default.
- A starvation counter guarantees DMA forward progress.
- Read responses are returned one cycle after grant, steered to the requester that issued the read.
- It sits between the LSU/DMA request logic and the `dccm_*_lo` inputs of the memory wrapper.

## Interface
Parameters:
- `ADDR_W`, 16, DCCM address width.
- `DATA_W`, 39, DCCM data width (32 data + 7 ECC, ECC precomputed by requester).
- `DMA_MAX_WAIT`, 8, consecutive cycles DMA may be denied before forced grant; legal range 1..255.

Ports (one clock; reset is asynchronous and active-high):
- `clock`  in  1  core clock.
- `reset`  in  1  asynchronous, active-high reset.
- `lsu_req_valid`  in  1  LSU request present.
- `lsu_req_write`  in  1  1 = write, 0 = read.
- `lsu_req_addr`  in  ADDR_W  LSU address.
- `lsu_req_wdata`  in  DATA_W  LSU write data.
- `lsu_req_ready`  out  1  LSU request accepted this cycle.
- `dma_req_valid`, `dma_req_write`, `dma_req_addr`, `dma_req_wdata`  in  1/1/ADDR_W/DATA_W  DMA request, same meaning as the LSU fields.
- `dma_req_ready`  out  1  DMA request accepted this cycle.
- `dccm_wren`  out  1  to memory write enable.
- `dccm_rden`  out  1  to memory read enable.
- `dccm_wr_addr_lo`  out  ADDR_W  memory write address.
- `dccm_rd_addr_lo`  out  ADDR_W  memory read address.
- `dccm_wr_data_lo`  out  DATA_W  memory write data.
- `dccm_rd_data_lo`  in  DATA_W  memory read data, valid the cycle after `dccm_rden`.
- `lsu_rsp_valid`  out  1  LSU read data valid.
- `dma_rsp_valid`  out  1  DMA read data valid.
- `rsp_data`  out  DATA_W  read data, shared by both requesters.
- `dma_starved`  out  1  FSM is in DMA_FORCE (status/perf).

## Operation
- Exactly one request is granted per cycle; grant = valid & ready, with no combinational path from ready to valid.
- FSM has two states:
  - NORMAL: LSU wins if `lsu_req_valid`; otherwise DMA wins if `dma_req_valid`.
  - DMA_FORCE: DMA wins if `dma_req_valid`; otherwise LSU wins. On any DMA grant, return to NORMAL and clear the counter.
- Starvation counter `wait_cnt`, width ceil(log2(DMA_MAX_WAIT+1)):
  - Increments in cycles where `dma_req_valid` is high and DMA is not granted.
  - Clears on a DMA grant or when `dma_req_valid` is low.
  - Saturates at DMA_MAX_WAIT.
  - Reaching DMA_MAX_WAIT moves the FSM NORMAL -> DMA_FORCE on the next edge.
- Granted write: `dccm_wren`=1; `dccm_wr_addr_lo` and `dccm_wr_data_lo` = winner's fields, all combinational in the grant cycle.
- Granted read: `dccm_rden`=1; `dccm_rd_addr_lo` = winner's address, combinational. A registered tag records the source.
- No grant: `dccm_wren`=`dccm_rden`=0. Address and data outputs hold the LSU fields, so they do not toggle on DMA noise.
- Response: in the cycle after a read grant, the tagged source's `*_rsp_valid`=1 and `rsp_data`=`dccm_rd_data_lo`. `rsp_data` is don't-care otherwise; the bench must not check it.
- Write-then-read to the same address in consecutive cycles returns the new data; the memory guarantees this, and the arbiter adds no hazard logic.
- DMA requester withdraws valid while in DMA_FORCE: FSM stays in DMA_FORCE and the counter stays cleared until the next DMA grant.

## Timing
- Reset values:
  - FSM = NORMAL, `wait_cnt`=0, response tag clear.
  - `lsu_rsp_valid`=`dma_rsp_valid`=0, `dma_starved`=0.
  - Ready and enable outputs are 0 while reset is asserted.
- Grant and memory enables: combinational, 0-cycle. Read latency request -> rsp_valid: exactly 1 cycle.
- Fully pipelined: a read may be granted every cycle, with one response per cycle.
- Reset asserted mid-operation: the pending response is dropped (no rsp_valid after reset release) and the FSM returns to NORMAL immediately (asynchronous).
- First forced grant under continuous LSU load occurs DMA_MAX_WAIT+1 cycles after DMA valid rises.

## Configuration
- `DCCM_ARB_STARVE_EN` defined: starvation counter, DMA_FORCE state and `dma_starved` present as above.
- Not defined: strict LSU priority with no counter; FSM permanently NORMAL; `dma_starved` tied 0; DMA may starve indefinitely.

## Test plan
- Reset: assert `reset` mid-read -> `lsu_rsp_valid`=`dma_rsp_valid`=0 next cycle, `dma_starved`=0, no enables.
- LSU read addr 0x0040 and DMA read addr 0x0080 both valid in cycle 0 -> `lsu_req_ready`=1, `dma_req_ready`=0, `dccm_rd_addr_lo`=0x0040; cycle 1 `lsu_rsp_valid`=1, `rsp_data`=memory word at 0x0040.
- Starvation, DMA_MAX_WAIT=8: LSU valid every cycle, DMA write 0x0100 valid from cycle 0 -> DMA granted at cycle 9, `dma_starved`=1 in cycle 9 only, LSU regains grant in cycle 10.
- Back-to-back: LSU write 0x0010 = 0x12_3456789A then LSU read 0x0010 the next cycle -> rsp_data = 0x12_3456789A one cycle later.
- Alternating reads LSU/DMA every cycle for 16 cycles -> each response flagged to the correct source, 16 responses, no drops.
- Macro undefined: LSU valid for 50 cycles with DMA valid -> `dma_req_ready` stays 0 and `dma_starved` stays 0 throughout.
